window_cache: RTL
=================

WINDOW_CACHE -- requirements
Module: window_cache

Interface
REQ-001 Parameter PRECISION, 8, bits per pixel.
REQ-002 Parameter KSIZE, 3, window height and width; legal range 2..7.
REQ-003 Parameter STRIDE, 1, horizontal window stride; legal range 1..4.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 module_en  input  1  block enable; low freezes all state.
REQ-007 over  input  1  synchronous frame-end clear.
REQ-008 row_switch_en  input  1  qualifies the accepted column as the first column of a new row.
REQ-009 din  input  PRECISION*KSIZE  one input column; lane r is at bits [(r+1)*PRECISION-1 : r*PRECISION], with r=0 as the top row.
REQ-010 din_valid  input  1  the din column is valid.
REQ-011 din_ready  output  1  the block can accept a column (combinational).
REQ-012 dout  output  PRECISION*KSIZE*KSIZE  window; element (r,c) is at index r*KSIZE+c, with c=0 as the oldest column.
REQ-013 dout_valid  output  1  window valid (registered).
REQ-014 dout_ready  input  1  downstream accepts the window.

Function
REQ-015 din_ready SHALL equal module_en & (!dout_valid | dout_ready).
REQ-016 An accept SHALL occur when din_valid & din_ready & !over.
REQ-017 On each accept, every window column c SHALL take column c+1, and column KSIZE-1 SHALL take din, lane for lane.
REQ-018 dout SHALL be driven directly from the window registers, so dout is stable while dout_valid=1 and dout_ready=0.
REQ-019 fill_cnt (0..KSIZE) SHALL update on accept: to 1 if row_switch_en=1; otherwise to min(fill_cnt+1, KSIZE).
REQ-020 row_switch_en SHALL be ignored when there is no accept.
REQ-021 An accept is "full" when the updated fill_cnt equals KSIZE.
REQ-022 skip_cnt (0..STRIDE-1) SHALL be cleared to 0 on a row_switch_en accept.
REQ-023 On a full accept with skip_cnt=0, the block SHALL emit the window and load skip_cnt with STRIDE-1.
REQ-024 On a full accept with skip_cnt>0, the block SHALL decrement skip_cnt and SHALL NOT emit.
REQ-025 On any cycle with an accept, dout_valid SHALL be set to the emit decision of that cycle; this covers simultaneous consume and refill.
REQ-026 On a cycle with no accept, dout_valid SHALL clear if dout_ready=1; otherwise it SHALL hold.
REQ-027 Latency SHALL be one clock from an emitting accept to dout_valid=1 with the new window on dout.
REQ-028 Emit cadence with no stalls SHALL be as follows: the first window is emitted on the KSIZE-th column of a row, then one window every STRIDE columns.
REQ-029 over=1 SHALL clear the window to 0 and clear fill_cnt, skip_cnt and dout_valid to 0, taking priority over a same-cycle accept; din_ready is unaffected.
REQ-030 module_en=0 SHALL hold the window, counters and dout_valid; no accept occurs and dout_ready is ignored.
REQ-031 fill_cnt SHALL saturate at KSIZE and never wrap.
REQ-032 skip_cnt SHALL never underflow.
REQ-033 A row_switch_en accept SHALL set dout_valid to 0, since KSIZE is at least 2.

Reset
REQ-034 While rst_n=0, the window, fill_cnt, skip_cnt and dout_valid SHALL be 0, and therefore dout=0.
REQ-035 Reset asserted mid-row SHALL discard all partial state immediately, without waiting for a clock.
REQ-036 After rst_n deasserts, the first column accepted SHALL count as fill_cnt=1 regardless of row_switch_en.

Verification
REQ-037 KSIZE=3, STRIDE=1, dout_ready=1; feed columns 0x01..0x05 with all lanes equal and row_switch_en on the first column -> dout_valid=1 one clock after columns 3, 4 and 5; the last window row 0 is 03,04,05.
REQ-038 KSIZE=3, STRIDE=2; feed 7 columns with no stall -> windows emitted after columns 3, 5 and 7 only.
REQ-039 Hold dout_ready=0 after the first window -> din_ready=0, and dout stays 01,02,03 per row while din_valid=1 for 5 clocks; raise dout_ready -> the next column is accepted in that same cycle and dout_valid stays 1.
REQ-040 After 2 columns, a row_switch_en accept -> fill_cnt=1, and the next window appears only after 2 more columns.
REQ-041 over pulsed in the same cycle as the accept that would fill the window -> dout_valid=0, window all zero, fill_cnt=0.
REQ-042 rst_n asserted asynchronously mid-row with dout_valid=1 -> dout_valid=0 and dout=0 before the next clock edge.

Source files
------------

// File: rtl/window_cache.sv
// Sliding KSIZE x KSIZE pixel window fed one column per accept; emits a window
// once a row has KSIZE columns, then every STRIDE columns, with a one-deep output handshake.
module window_cache #(
    parameter int unsigned PRECISION = 8,
    parameter int unsigned KSIZE     = 3,
    parameter int unsigned STRIDE    = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                module_en,
    input  logic                                over,
    input  logic                                row_switch_en,
    input  logic [PRECISION*KSIZE-1:0]          din,
    input  logic                                din_valid,
    output logic                                din_ready,
    output logic [PRECISION*KSIZE*KSIZE-1:0]    dout,
    output logic                                dout_valid,
    input  logic                                dout_ready
);

    localparam int unsigned FW = $clog2(KSIZE + 1);
    localparam int unsigned SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned WW = PRECISION * KSIZE * KSIZE;
    localparam logic [FW-1:0] FILL_MAX    = FW'(KSIZE);
    localparam logic [SW-1:0] SKIP_RELOAD = SW'(STRIDE - 1);

    logic [WW-1:0] win_q, win_d, win_shift;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d, fill_next;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d;
    logic          valid_q, valid_d;
    logic          accept, full, emit;

    assign din_ready  = module_en & (~valid_q | dout_ready);
    assign accept     = din_valid & din_ready & ~over;
    assign dout       = win_q;
    assign dout_valid = valid_q;

    // A row switch restarts the row at one column, so it can never complete a window.
    assign fill_next = row_switch_en ? FW'(1)
                     : ((fill_cnt_q == FILL_MAX) ? FILL_MAX : fill_cnt_q + 1'b1);
    assign full      = (fill_next == FILL_MAX);
    assign emit      = full && (skip_cnt_q == '0);

    // Column c takes column c+1; the newest column (KSIZE-1) takes din lane by lane.
    always_comb begin
        win_shift = win_q;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if (c < KSIZE - 1) begin
                    win_shift[(r*KSIZE + c)*PRECISION +: PRECISION] =
                        win_q[(r*KSIZE + c + 1)*PRECISION +: PRECISION];
                end else begin
                    win_shift[(r*KSIZE + c)*PRECISION +: PRECISION] =
                        din[r*PRECISION +: PRECISION];
                end
            end
        end
    end

    always_comb begin
        win_d      = win_q;
        fill_cnt_d = fill_cnt_q;
        skip_cnt_d = skip_cnt_q;
        valid_d    = valid_q;
        if (module_en) begin
            if (over) begin
                win_d      = '0;
                fill_cnt_d = '0;
                skip_cnt_d = '0;
                valid_d    = 1'b0;
            end else if (accept) begin
                win_d      = win_shift;
                fill_cnt_d = fill_next;
                valid_d    = emit;
                if (row_switch_en) begin
                    skip_cnt_d = '0;
                end else if (full) begin
                    skip_cnt_d = emit ? SKIP_RELOAD : skip_cnt_q - 1'b1;
                end
            end else if (dout_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            fill_cnt_q <= '0;
            skip_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            win_q      <= win_d;
            fill_cnt_q <= fill_cnt_d;
            skip_cnt_q <= skip_cnt_d;
            valid_q    <= valid_d;
        end
    end

endmodule
